// File: rtl/reg_cmd_pkg.sv
// -----------------------------------------------------------------------------
// reg_cmd_pkg
// Shared definitions for the register-file command front-end:
//   - command opcodes carried in the first byte of a frame
//   - FSM state encodings (plain localparams so they can be dumped or compared
//     against legacy tooling that expects fixed numeric codes)
//   - a helper that tells whether a state lies inside an incoming frame
// -----------------------------------------------------------------------------
package reg_cmd_pkg;

    localparam logic [7:0] CMD_WR = 8'hAA;
    localparam logic [7:0] CMD_RD = 8'hBB;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WR_ADDR = 3'd1;
    localparam state_t ST_WR_DATA = 3'd2;
    localparam state_t ST_RD_ADDR = 3'd3;
    localparam state_t ST_RD_WAIT = 3'd4;
    localparam state_t ST_TX_SEND = 3'd5;

    // True while the FSM is waiting for the next byte of a partly received frame;
    // the inter-byte timeout only runs in these states.
    function automatic logic in_frame(input state_t st);
        return (st == ST_WR_ADDR) || (st == ST_WR_DATA) || (st == ST_RD_ADDR);
    endfunction

endpackage

// File: rtl/reg_cmd_timer.sv
// -----------------------------------------------------------------------------
// reg_cmd_timer
// Saturating cycle counter with synchronous clear and a terminal-count flag.
// tc is high during the LIMIT-th enabled cycle after a clear, so a caller that
// acts on tc leaves its state after exactly LIMIT cycles. The count never wraps.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   clr  in  clear counter to zero (priority over en)
//   en   in  count this cycle
//   tc   out terminal count reached (count == LIMIT-1)
// -----------------------------------------------------------------------------
module reg_cmd_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != TC_VAL)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/reg_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// reg_cmd_ctrl
// Command front-end for the 8x16 register file. Decodes byte frames from the
// UART RX path into one-cycle WrEn/RdEn strobes and returns read data on the
// UART TX path. One frame in flight at a time.
//   write frame: 0xAA, addr, data
//   read  frame: 0xBB, addr        -> one response byte on TX
// All outputs are registered: a byte accepted in cycle N drives its strobe in
// cycle N+1.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   RX_P_DATA     received byte, valid with RX_D_VLD
//   RX_D_VLD      one-cycle strobe per received byte
//   WrEn, RdEn    register file write / read strobes (one cycle)
//   Address       register file address, held from addr byte to end of frame
//   WrData        write data, valid with WrEn
//   RdData        read data, valid with RdData_Valid
//   RdData_Valid  read-data strobe from register file
//   TX_P_DATA     response byte, held while TX_D_VLD=1
//   TX_D_VLD      response valid, held until TX_Busy=0
//   TX_Busy       UART TX busy
//   CMD_ERR       one-cycle pulse on any protocol error or abort
// -----------------------------------------------------------------------------
module reg_cmd_ctrl
    import reg_cmd_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int RD_TIMEOUT    = 16,
    parameter int FRAME_TIMEOUT = 4096
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         RX_P_DATA,
    input  logic                     RX_D_VLD,
    output logic                     WrEn,
    output logic                     RdEn,
    output logic [ADDRESS_WIDTH-1:0] Address,
    output logic [WIDTH-1:0]         WrData,
    input  logic [WIDTH-1:0]         RdData,
    input  logic                     RdData_Valid,
    output logic [WIDTH-1:0]         TX_P_DATA,
    output logic                     TX_D_VLD,
    input  logic                     TX_Busy,
    output logic                     CMD_ERR
);

    localparam logic [WIDTH-1:0] OP_WR = WIDTH'(CMD_WR);
    localparam logic [WIDTH-1:0] OP_RD = WIDTH'(CMD_RD);

    state_t                   state_q,   state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q,    addr_d;
    logic [WIDTH-1:0]         wr_data_q, wr_data_d;
    logic                     wr_en_q,   wr_en_d;
    logic                     rd_en_q,   rd_en_d;
    logic [WIDTH-1:0]         tx_data_q, tx_data_d;
    logic                     tx_vld_q,  tx_vld_d;
    logic                     cmd_err_q, cmd_err_d;

    logic frame_clr;
    logic frame_tc;
    logic rd_clr;
    logic rd_tc;
    logic addr_ok;

    // Inter-byte timeout: runs only while a frame is half received and restarts
    // on every byte, so it measures silence rather than total frame length.
    assign frame_clr = !in_frame(state_q) || RX_D_VLD;

    reg_cmd_timer #(
        .LIMIT (FRAME_TIMEOUT)
    ) u_frame_timer (
        .clk (CLK),
        .rst (RST),
        .clr (frame_clr),
        .en  (1'b1),
        .tc  (frame_tc)
    );

    // Read-response timeout: starts from zero on entry to RD_WAIT.
    assign rd_clr = (state_q != ST_RD_WAIT);

    reg_cmd_timer #(
        .LIMIT (RD_TIMEOUT)
    ) u_rd_timer (
        .clk (CLK),
        .rst (RST),
        .clr (rd_clr),
        .en  (1'b1),
        .tc  (rd_tc)
    );

    // Address bytes must fit the register file; any high bit set is an error.
    assign addr_ok = (RX_P_DATA[WIDTH-1:ADDRESS_WIDTH] == '0);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = tx_vld_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        cmd_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == OP_WR) begin
                        state_d = ST_WR_ADDR;
                    end else if (RX_P_DATA == OP_RD) begin
                        state_d = ST_RD_ADDR;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end

            ST_WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d = RX_P_DATA[ADDRESS_WIDTH-1:0];
                    if (addr_ok) begin
                        state_d = ST_WR_DATA;
                    end else begin
                        cmd_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else if (frame_tc) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_data_d = RX_P_DATA;
                    wr_en_d   = 1'b1;
                    state_d   = ST_IDLE;
                end else if (frame_tc) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d = RX_P_DATA[ADDRESS_WIDTH-1:0];
                    if (addr_ok) begin
                        rd_en_d = 1'b1;
                        state_d = ST_RD_WAIT;
                    end else begin
                        cmd_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else if (frame_tc) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            ST_RD_WAIT: begin
                // A byte here would start a second frame; it is dropped.
                if (RX_D_VLD) begin
                    cmd_err_d = 1'b1;
                end
                if (RdData_Valid) begin
                    tx_data_d = RdData;
                    tx_vld_d  = 1'b1;
                    state_d   = ST_TX_SEND;
                end else if (rd_tc) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            ST_TX_SEND: begin
                if (RX_D_VLD) begin
                    cmd_err_d = 1'b1;
                end
                // TX_D_VLD is high in this state, so Busy low means accepted.
                if (!TX_Busy) begin
                    tx_vld_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                tx_vld_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign WrEn      = wr_en_q;
    assign RdEn      = rd_en_q;
    assign Address   = addr_q;
    assign WrData    = wr_data_q;
    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign CMD_ERR   = cmd_err_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_cmd_ctrl
// Scoreboard bench for reg_cmd_ctrl. Stimulus pushes the expected DUT events
// (write strobe, read strobe, TX byte accepted, error pulse) in order; a
// negedge monitor pops and compares them as the DUT produces them. A small
// register-file responder answers RdEn one cycle later.
// -----------------------------------------------------------------------------
module tb_reg_cmd_ctrl;

    localparam int EV_WR  = 0;
    localparam int EV_RD  = 1;
    localparam int EV_TX  = 2;
    localparam int EV_ERR = 3;

    typedef struct {
        int         kind;
        logic [3:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] RX_P_DATA = '0;
    logic       RX_D_VLD = 1'b0;
    logic       WrEn, RdEn;
    logic [3:0] Address;
    logic [7:0] WrData;
    logic [7:0] RdData;
    logic       RdData_Valid;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       TX_Busy = 1'b0;
    logic       CMD_ERR;

    ev_t        exp_q[$];
    int         n_vec  = 0;
    int         n_miss = 0;
    int         tx_seen = 0;
    logic       rsp_en = 1'b1;
    logic       busy_rand = 1'b0;
    logic [7:0] model_mem [16];
    logic [7:0] rf_mem [16];

    reg_cmd_ctrl #(
        .WIDTH         (8),
        .ADDRESS_WIDTH (4),
        .RD_TIMEOUT    (16),
        .FRAME_TIMEOUT (4096)
    ) dut (
        .CLK          (clk),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD),
        .TX_Busy      (TX_Busy),
        .CMD_ERR      (CMD_ERR)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (busy_rand) TX_Busy = 1'($urandom_range(0, 1));
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        step();
        RX_D_VLD  = 1'b0;
    endtask

    task automatic push_ev(input int kind, input logic [3:0] addr, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [7:0] data);
        push_ev(EV_WR, addr, data);
        model_mem[addr] = data;
        send_byte(8'hAA);
        send_byte({4'h0, addr});
        send_byte(data);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    task automatic pop_expect(input string tag, input int kind, input logic [3:0] addr,
                              input logic [7:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_unexpected"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_kind"}, kind, e.kind);
            if (kind == e.kind && (kind == EV_WR || kind == EV_RD))
                check_eq({tag, "_addr"}, addr, e.addr);
            if (kind == e.kind && (kind == EV_WR || kind == EV_TX))
                check_eq({tag, "_data"}, data, e.data);
        end
    endtask

    // Register-file responder: stores writes, answers a read one cycle after RdEn.
    always @(negedge clk) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) rf_mem[i] = 8'h00;
            RdData_Valid = 1'b0;
            RdData       = 8'h00;
        end else begin
            if (WrEn) rf_mem[Address] = WrData;
            RdData_Valid = rsp_en && RdEn;
            RdData       = RdEn ? rf_mem[Address] : 8'h00;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (WrEn === 1'b1) begin
            check_eq("wr_rd_excl", RdEn, 0);
            pop_expect("wr", EV_WR, Address, WrData);
        end
        if (RdEn === 1'b1) pop_expect("rd", EV_RD, Address, 8'h00);
        if (TX_D_VLD === 1'b1 && TX_Busy === 1'b0) begin
            pop_expect("tx", EV_TX, 4'h0, TX_P_DATA);
            tx_seen++;
        end
        if (CMD_ERR === 1'b1) pop_expect("err", EV_ERR, 4'h0, 8'h00);
    end

    initial begin
        int n;
        int target;
        logic [3:0] a;
        logic [7:0] d;

        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;

        // Reset state
        RST = 1'b1;
        step();
        step();
        check_eq("rst_wren",   WrEn, 0);
        check_eq("rst_rden",   RdEn, 0);
        check_eq("rst_txvld",  TX_D_VLD, 0);
        check_eq("rst_cmderr", CMD_ERR, 0);
        check_eq("rst_addr",   Address, 0);
        check_eq("rst_wrdata", WrData, 0);
        check_eq("rst_txdata", TX_P_DATA, 0);
        RST = 1'b0;
        step();

        // Write AA,03,5C
        do_write(4'h3, 8'h5C);
        drain(20);

        // Read BB,03 with TX held busy for 10 cycles
        TX_Busy = 1'b1;
        push_ev(EV_RD, 4'h3, 8'h00);
        push_ev(EV_TX, 4'h0, model_mem[3]);
        send_byte(8'hBB);
        send_byte(8'h03);
        n = 0;
        while (TX_D_VLD !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check_eq("tx_vld_rise", TX_D_VLD, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("tx_hold", TX_D_VLD, 1);
        end
        check_eq("tx_data_held", TX_P_DATA, 8'h5C);
        TX_Busy = 1'b0;
        step();
        check_eq("tx_drop", TX_D_VLD, 0);
        drain(20);

        // Bad opcode
        push_ev(EV_ERR, 4'h0, 8'h00);
        send_byte(8'h12);
        drain(20);

        // Out-of-range address on write
        push_ev(EV_ERR, 4'h0, 8'h00);
        send_byte(8'hAA);
        send_byte(8'h1F);
        drain(20);

        // Read with no response: error after 16 cycles in RD_WAIT
        rsp_en = 1'b0;
        push_ev(EV_RD, 4'h5, 8'h00);
        push_ev(EV_ERR, 4'h0, 8'h00);
        send_byte(8'hBB);
        send_byte(8'h05);
        n = 0;
        while (CMD_ERR !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check_eq("rd_timeout_lat", n, 16);
        drain(20);

        // Byte arriving in RD_WAIT is dropped with an error, then timeout
        push_ev(EV_RD, 4'h6, 8'h00);
        push_ev(EV_ERR, 4'h0, 8'h00);
        push_ev(EV_ERR, 4'h0, 8'h00);
        send_byte(8'hBB);
        send_byte(8'h06);
        send_byte(8'h55);
        drain(100);
        rsp_en = 1'b1;

        // Frame timeout after AA, then a normal write
        push_ev(EV_ERR, 4'h0, 8'h00);
        send_byte(8'hAA);
        n = 0;
        while (CMD_ERR !== 1'b1 && n < 5000) begin
            step();
            n++;
        end
        check_eq("frame_to_lat", n, 4096);
        drain(20);
        do_write(4'h1, 8'h77);
        drain(20);

        // Reset mid-frame: AA,02, RST, then 0x99 errors from IDLE with no write
        send_byte(8'hAA);
        send_byte(8'h02);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_eq("midrst_cmderr", CMD_ERR, 0);
        push_ev(EV_ERR, 4'h0, 8'h00);
        send_byte(8'h99);
        drain(20);

        // Responder memory was cleared by reset; mirror that in the model.
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;

        // Stress: back-to-back frames, random TX_Busy
        busy_rand = 1'b1;
        for (int f = 0; f < 60; f++) begin
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                target = tx_seen + 1;
                push_ev(EV_RD, a, 8'h00);
                push_ev(EV_TX, 4'h0, model_mem[a]);
                send_byte(8'hBB);
                send_byte({4'h0, a});
                n = 0;
                while (tx_seen < target && n < 300) begin
                    step();
                    n++;
                end
                check_eq("stress_tx_wait", tx_seen, target);
            end else begin
                d = 8'($urandom_range(0, 255));
                do_write(a, d);
            end
        end
        busy_rand = 1'b0;
        TX_Busy   = 1'b0;
        drain(100);
        for (int i = 0; i < 5; i++) step();
        check_eq("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
